sec_a2b_seq: RTL and testbench

- Sequencer for the 8-share, 32-bit masked A2B converter core.
- Gathers the core's wide fresh-randomness vector from a narrow RNG stream.
- Accepts one arithmetic-share request at a time and drives the core's data-valid and enable strobes.
- Watches for completion and returns the Boolean shares over a valid/ready response channel; randomness is never reused across conversions.

---
 rtl/sec_a2b_seq.sv | 169 ++++++++++++++++
 tb/tb_sec_a2b_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sec_a2b_seq.sv
// rtl/sec_a2b_seq.sv - sequencer for the 8-share 32-bit masked A2B core: RNG gather, issue, completion, response.
// Define SEC_A2B_SEQ_PREFETCH_EN for ping-pong randomness banks; the default build uses a single bank.
module sec_a2b_seq #(
    parameter int RAND_W  = 11328,
    parameter int RNG_W   = 64,
    parameter int SHARE_W = 256,
    parameter int TIMEOUT = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               rng_valid_i,
    input  logic [RNG_W-1:0]   rng_data_i,
    output logic               rng_ready_o,
    input  logic               req_valid_i,
    input  logic [SHARE_W-1:0] req_a_i,
    output logic               req_ready_o,
    output logic               core_dvld_o,
    output logic               core_rvld_o,
    output logic [RAND_W-1:0]  core_n_o,
    output logic [SHARE_W-1:0] core_a_o,
    input  logic [SHARE_W-1:0] core_z_i,
    input  logic               core_dvld_i,
    output logic               rsp_valid_o,
    output logic [SHARE_W-1:0] rsp_z_o,
    input  logic               rsp_ready_i,
    output logic               err_o
);
    localparam int N_WORDS = (RAND_W + RNG_W - 1) / RNG_W;
    localparam int CW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int OW      = $clog2(RAND_W);
    localparam int TW      = $clog2(TIMEOUT + 1);
`ifdef SEC_A2B_SEQ_PREFETCH_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    typedef enum logic [2:0] {S_FILL, S_READY, S_ISSUE, S_BUSY, S_RESP} state_t;

    state_t                     state_q, state_d;
    logic [NB-1:0][RAND_W-1:0]  bank_q;
    logic [NB-1:0][CW-1:0]      cnt_q;
    logic [NB-1:0]              wr, clr;
    logic [CW-1:0]              fill_cnt;
    logic [RAND_W-1:0]          wdata_sh;
    logic [OW-1:0]              off;
    logic [SHARE_W-1:0]         a_q, z_q;
    logic [TW-1:0]              tmo_q;
    logic                       err_q, live_q;
    logic                       take, done, expire, finish, nfull;

    // live_q keeps rng_ready_o low while reset is asserted and for the first edge after it
    assign take   = rng_valid_i & rng_ready_o;
    assign done   = take & (fill_cnt == CW'(N_WORDS - 1));
    assign expire = (state_q == S_BUSY) & ~core_dvld_i & (tmo_q == TW'(TIMEOUT - 1));
    assign finish = ((state_q == S_RESP) & rsp_ready_i) | expire;

    // Shifting past RAND_W drops the excess bits of a short final word
    assign off      = OW'(fill_cnt) * OW'(RNG_W);
    assign wdata_sh = {{(RAND_W - RNG_W){1'b0}}, rng_data_i} << off;

`ifdef SEC_A2B_SEQ_PREFETCH_EN
    logic          act_q, fsel;
    logic [NB-1:0] full_q;

    assign fsel        = (state_q == S_FILL) ? act_q : ~act_q;
    assign rng_ready_o = live_q & ((state_q == S_FILL) | ~full_q[~act_q]);
    assign fill_cnt    = cnt_q[fsel];
    assign wr          = {fsel & take, ~fsel & take};
    assign clr         = {act_q & finish, ~act_q & finish};
    assign nfull       = full_q[~act_q] | done;
    assign core_n_o    = bank_q[act_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_q  <= 1'b0;
            full_q <= '0;
        end else begin
            if (finish) act_q <= ~act_q;
            for (int b = 0; b < NB; b++) begin
                if (clr[b])             full_q[b] <= 1'b0;
                else if (wr[b] && done) full_q[b] <= 1'b1;
            end
        end
    end
`else
    assign rng_ready_o = live_q & (state_q == S_FILL);
    assign fill_cnt    = cnt_q[0];
    assign wr          = take;
    assign clr         = finish;
    assign nfull       = 1'b0;
    assign core_n_o    = bank_q[0];
`endif

    // Each slot is zero before it is written (reset or zeroize), so OR-in suffices
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bank_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (clr[b]) begin
                    bank_q[b] <= '0;
                    cnt_q[b]  <= '0;
                end else if (wr[b]) begin
                    bank_q[b] <= bank_q[b] | wdata_sh;
                    cnt_q[b]  <= done ? '0 : cnt_q[b] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_FILL;
            live_q  <= 1'b0;
            a_q     <= '0;
            z_q     <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
            if (state_q == S_READY && req_valid_i) a_q <= req_a_i;
            else if (finish)                       a_q <= '0;
            if (state_q == S_BUSY && core_dvld_i) z_q <= core_z_i;
            // Counts cycles since the issue pulse, so expiry lands TIMEOUT cycles after it
            if (state_q == S_ISSUE)     tmo_q <= TW'(1);
            else if (state_q == S_BUSY) tmo_q <= tmo_q + 1'b1;
            if (expire) err_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        core_dvld_o = 1'b0;
        core_rvld_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            S_FILL: begin
                if (done) state_d = S_READY;
            end
            S_READY: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                core_dvld_o = 1'b1;
                core_rvld_o = 1'b1;
                state_d     = S_BUSY;
            end
            S_BUSY: begin
                core_rvld_o = 1'b1;
                if (core_dvld_i) state_d = S_RESP;
                else if (expire) state_d = nfull ? S_READY : S_FILL;
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = nfull ? S_READY : S_FILL;
            end
            default: state_d = S_FILL;
        endcase
    end

    assign core_a_o = a_q;
    assign rsp_z_o  = z_q;
    assign err_o    = err_q;
endmodule

// File: tb/tb_sec_a2b_seq.sv
// tb/tb_sec_a2b_seq.sv - scoreboard bench for sec_a2b_seq: fill, issue, response, timeout, reset.
module tb_sec_a2b_seq;
    localparam int RAND_W  = 11328;
    localparam int RNG_W   = 64;
    localparam int SHARE_W = 256;
    localparam int TIMEOUT = 64;

    logic               clk = 1'b0;
    logic               rst_ni = 1'b0;
    logic               rng_valid_i = 1'b0;
    logic [RNG_W-1:0]   rng_data_i = '0;
    logic               rng_ready_o;
    logic               req_valid_i = 1'b0;
    logic [SHARE_W-1:0] req_a_i = '0;
    logic               req_ready_o;
    logic               core_dvld_o, core_rvld_o;
    logic [RAND_W-1:0]  core_n_o;
    logic [SHARE_W-1:0] core_a_o;
    logic [SHARE_W-1:0] core_z_i = '0;
    logic               core_dvld_i = 1'b0;
    logic               rsp_valid_o;
    logic [SHARE_W-1:0] rsp_z_o;
    logic               rsp_ready_i = 1'b0;
    logic               err_o;

    localparam logic [SHARE_W-1:0] A1 = 256'h1;
    localparam logic [SHARE_W-1:0] Z1 = {32{8'hA5}};
    localparam logic [SHARE_W-1:0] A2 = {8{32'h1234_5678}};
    localparam logic [SHARE_W-1:0] Z2 = {8{32'h0F1E_2D3C}};
    localparam logic [SHARE_W-1:0] A3 = {8{32'hDEAD_BEEF}};

    int total = 0;
    int bad = 0;
    int core_lat = -1;
    logic [SHARE_W-1:0] zpat = '0;
    logic [SHARE_W-1:0] exp_q[$];
    int fcyc;

    sec_a2b_seq #(.RAND_W(RAND_W), .RNG_W(RNG_W), .SHARE_W(SHARE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .rng_valid_i(rng_valid_i), .rng_data_i(rng_data_i), .rng_ready_o(rng_ready_o),
        .req_valid_i(req_valid_i), .req_a_i(req_a_i), .req_ready_o(req_ready_o),
        .core_dvld_o(core_dvld_o), .core_rvld_o(core_rvld_o), .core_n_o(core_n_o),
        .core_a_o(core_a_o), .core_z_i(core_z_i), .core_dvld_i(core_dvld_i),
        .rsp_valid_o(rsp_valid_o), .rsp_z_o(rsp_z_o), .rsp_ready_i(rsp_ready_i),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [SHARE_W-1:0] got, input logic [SHARE_W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    function automatic logic any_out();
        return |{rng_ready_o, req_ready_o, core_dvld_o, core_rvld_o, rsp_valid_o, err_o,
                 core_n_o, core_a_o, rsp_z_o};
    endfunction

    always @(negedge clk) begin
        #2;
        if (rst_ni && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
            else chk("rsp_z", rsp_z_o, exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        #1;
        if (core_dvld_o && core_lat >= 0) begin
            repeat (core_lat) @(negedge clk);
            core_dvld_i = 1'b1;
            core_z_i    = zpat;
            @(negedge clk);
            core_dvld_i = 1'b0;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        chk("reset_outputs_zero", any_out(), 0);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic feed(input int n, input int base, input bit toggle);
        int got = 0;
        int cyc = 0;
        bit ph = 1'b1;
        bit early = 1'b0;
        while (got < n && cyc < 4000) begin
            @(negedge clk);
            rng_valid_i = ph;
            rng_data_i  = RNG_W'(base + got);
            if (toggle) ph = ~ph;
            #1;
            if (req_ready_o) early = 1'b1;
            if (rng_valid_i && rng_ready_o) got++;
            cyc++;
        end
        fcyc = cyc;
        chk("feed_words", got, n);
        chk("no_early_req_ready", early, 0);
    endtask

    task automatic do_req(input logic [SHARE_W-1:0] a);
        @(negedge clk);
        rng_valid_i = 1'b0;
        req_valid_i = 1'b1;
        req_a_i     = a;
        #1;
        chk("req_ready", req_ready_o, 1);
        @(negedge clk);
        req_valid_i = 1'b0;
        #1;
        chk("issue_pulse", core_dvld_o, 1);
        chk("core_a_latched", core_a_o, a);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid_o && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rsp_arrives", rsp_valid_o, 1);
    endtask

`ifdef SEC_A2B_SEQ_PREFETCH_EN
    bit rng_auto = 1'b0;
    int auto_cnt = 0;
    always @(negedge clk) begin
        if (rng_auto) begin
            rng_valid_i = 1'b1;
            rng_data_i  = RNG_W'(auto_cnt);
            #1;
            if (rng_ready_o) auto_cnt++;
        end
    end
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        apply_reset();
`ifdef SEC_A2B_SEQ_PREFETCH_EN
        begin
            logic [RAND_W-1:0] n1;
            int issues = 0;
            int h = -1;
            int cyc = 0;
            bit ok = 1'b0;
            rng_auto = 1'b1;
            for (int i = 0; i < 1000 && !ok; i++) begin
                @(negedge clk);
                #2;
                ok = req_ready_o && !rng_ready_o;
            end
            chk("both_banks_full", ok, 1);
            core_lat = 20;
            zpat = Z1;
            exp_q.push_back(Z1);
            exp_q.push_back(Z1);
            rsp_ready_i = 1'b1;
            req_a_i     = A1;
            req_valid_i = 1'b1;
            n1 = '0;
            while (issues < 2 && cyc < 300) begin
                @(negedge clk);
                #2;
                cyc++;
                if (core_dvld_o) begin
                    issues++;
                    if (issues == 1) n1 = core_n_o;
                    else begin
                        chk("b2b_gap", cyc - h, 2);
                        chk("fresh_rand", n1 != core_n_o, 1);
                        req_valid_i = 1'b0;
                    end
                end
                if (rsp_valid_o && rsp_ready_i && h < 0) h = cyc;
            end
            chk("two_issues", issues, 2);
            repeat (40) @(negedge clk);
            rsp_ready_i = 1'b0;
        end
`else
        // Fill with data=k, then check packing and the READY edge
        feed(177, 0, 1'b0);
        @(negedge clk);
        rng_valid_i = 1'b0;
        #1;
        chk("req_ready_after_fill", req_ready_o, 1);
        chk("n_word0", core_n_o[63:0], 0);
        chk("n_word90", core_n_o[90*64 +: 64], 90);
        chk("n_word176", core_n_o[RAND_W-1 -: 64], 176);

        core_lat = 12;
        zpat = Z1;
        exp_q.push_back(Z1);
        do_req(A1);
        @(negedge clk);
        #1;
        chk("pulse_one_cycle", core_dvld_o, 0);
        chk("rvld_busy", core_rvld_o, 1);
        wait_rsp(n);
        chk("rsp_latency", n, 12);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (i == 4) rsp_ready_i = 1'b1;
                #1;
            end
            chk("rsp_valid_hold", rsp_valid_o, 1);
            chk("rsp_z_hold", rsp_z_o, Z1);
            chk("rvld_low_resp", core_rvld_o, 0);
        end
        @(negedge clk);
        rsp_ready_i = 1'b0;
        #1;
        chk("rsp_done", rsp_valid_o, 0);
        chk("n_zeroized", |core_n_o, 0);
        chk("a_zeroized", core_a_o, 0);
        chk("back_to_fill", rng_ready_o, 1);

        // Core never answers: timeout
        feed(177, 300, 1'b0);
        core_lat = -1;
        do_req(A3);
        begin
            bit seen = 1'b0;
            for (int i = 1; i <= TIMEOUT; i++) begin
                @(negedge clk);
                #1;
                if (rsp_valid_o) seen = 1'b1;
                if (i == TIMEOUT - 1) chk("err_before_timeout", err_o, 0);
            end
            chk("err_at_timeout", err_o, 1);
            chk("fill_after_timeout", rng_ready_o, 1);
            chk("no_rsp_on_timeout", seen, 0);
            chk("n_zero_timeout", |core_n_o, 0);
        end

        // Toggling RNG with a request pending from reset
        req_a_i     = A2;
        req_valid_i = 1'b1;
        apply_reset();
        feed(177, 0, 1'b1);
        chk("toggle_fill_cycles", fcyc, 353);
        core_lat = 3;
        zpat = Z2;
        exp_q.push_back(Z2);
        @(negedge clk);
        rng_valid_i = 1'b0;
        #1;
        chk("req_ready_toggle", req_ready_o, 1);
        @(negedge clk);
        req_valid_i = 1'b0;
        #1;
        chk("issue_toggle", core_dvld_o, 1);
        chk("core_a_toggle", core_a_o, A2);
        rsp_ready_i = 1'b1;
        repeat (10) @(negedge clk);
        rsp_ready_i = 1'b0;

        // Reset during BUSY and during a partial fill
        feed(177, 500, 1'b0);
        core_lat = -1;
        do_req(A1);
        repeat (5) @(negedge clk);
        apply_reset();
        feed(90, 700, 1'b0);
        apply_reset();
        feed(176, 900, 1'b0);
        feed(1, 1076, 1'b0);
        @(negedge clk);
        rng_valid_i = 1'b0;
        #1;
        chk("ready_after_fresh_fill", req_ready_o, 1);
        chk("fresh_word0", core_n_o[63:0], 900);
        chk("fresh_word176", core_n_o[RAND_W-1 -: 64], 1076);
`endif
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
